// File: rtl/lc3_fetch_ctrl_pkg.sv
// Shared types and constants for the LC-3 instruction-fetch sequencer.
// Holds the FSM state encoding, PC mux selects and the timer sizing helper.
package lc3_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    VALID  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BUS = 2'b01;
  localparam logic [1:0] PC_SEL_EA  = 2'b10;

  // A zero TIMEOUT disables the timeout but still needs a legal 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned timeout);
    if (timeout == 0) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lc3_fetch_ctrl_timer.sv
// Memory wait-state timer for the fetch sequencer: counts stalled FETCH2 cycles
// and flags the cycle on which the last permitted wait is being spent.
module fetch_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import lc3_fetch_pkg::*;

  localparam int unsigned TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TMAX  = '1;
  localparam logic [TW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Saturates rather than wrapping so a long stall can never alias back to zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TMAX)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 instruction-fetch sequencer: drives the PC stage, runs the memory read
// handshake through MAR/MDR, and hands IR to decode with a valid/ack pair.
module lc3_fetch_ctrl #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic          flush,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_r,
  input  logic          ir_ack,
  output logic          gate_pc_en,
  output logic          ld_pc,
  output logic [1:0]    pc_sel,
  output logic          mem_en,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic          busy,
  output logic          fetch_err
);
  import lc3_fetch_pkg::*;

  fetch_state_e  state_q, state_d;
  logic [DW-1:0] mar_q, mdr_q, ir_q;
  logic          err_q, err_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  assign tmr_clear = (state_q != FETCH2);
  assign tmr_en    = (state_q == FETCH2) && !mem_r;

  fetch_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req) state_d = FETCH1;
        end
        FETCH1: state_d = FETCH2;
        FETCH2: begin
          if (mem_r) begin
            state_d = FETCH3;
          end else if (tmr_expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        FETCH3: state_d = VALID;
        VALID: begin
          if (ir_ack) state_d = fetch_req ? FETCH1 : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Flush blocks every register load so MAR/MDR/IR keep their prior contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (!flush) begin
        if (state_q == FETCH1) mar_q <= pc;
        if ((state_q == FETCH2) && mem_r) mdr_q <= mem_rdata;
        if (state_q == FETCH3) ir_q <= mdr_q;
      end
    end
  end

  assign gate_pc_en = (state_q == FETCH1);
  assign ld_pc      = (state_q == FETCH1);
  assign pc_sel     = PC_SEL_INC;
  assign mem_en     = (state_q == FETCH2);
  assign mem_addr   = mar_q;
  assign ir         = ir_q;
  assign ir_valid   = (state_q == VALID);
  assign busy       = (state_q != IDLE);
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Bench for lc3_fetch_ctrl: behavioural fetch model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lc3_fetch_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc_stub = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_r = 1'b0;
  logic        ir_ack = 1'b0;
  logic        gate_pc_en, ld_pc, mem_en, ir_valid, busy, fetch_err;
  logic [1:0]  pc_sel;
  logic [15:0] mem_addr, ir;

  logic        pc_ld_req = 1'b0;
  logic [15:0] pc_ld_val = 16'h0000;
  bit          chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  lc3_fetch_ctrl #(
    .DW      (16),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .pc         (pc_stub),
    .mem_rdata  (mem_rdata),
    .mem_r      (mem_r),
    .ir_ack     (ir_ack),
    .gate_pc_en (gate_pc_en),
    .ld_pc      (ld_pc),
    .pc_sel     (pc_sel),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    case (a)
      16'h3000: return 16'h1261;
      16'h3001: return 16'h0FFE;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  // Memory returns junk unless it is signalling ready.
  assign mem_rdata = mem_r ? mem_lookup(mem_addr) : 16'hDEAD;

  // Upstream PC stage: increments whenever the sequencer pulses ld_pc.
  always @(posedge clk) begin
    if (pc_ld_req) pc_stub <= pc_ld_val;
    else if (ld_pc) pc_stub <= pc_stub + 16'h0001;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one flag per activity the sequencer can be engaged in.
  bit          m_load, m_wait, m_xfer, m_hold, m_err;
  int          m_cnt;
  logic [15:0] m_mar, m_mdr, m_ir;

  always @(posedge clk) begin : model
    bit start, nl, nw, nt, nh, ne;
    if (rst) begin
      m_load = 0; m_wait = 0; m_xfer = 0; m_hold = 0; m_err = 0; m_cnt = 0;
      m_mar = '0; m_mdr = '0; m_ir = '0;
    end else begin
      start = fetch_req && ((!m_load && !m_wait && !m_xfer && !m_hold) || (m_hold && ir_ack));
      nl = 0; nw = 0; nt = 0; ne = 0;
      nh = m_hold && !ir_ack;
      if (flush) begin
        nh = 0;
      end else begin
        if (m_load) begin
          m_mar = pc_stub;
          m_cnt = 0;
          nw = 1;
        end
        if (m_wait) begin
          if (mem_r) begin
            m_mdr = mem_rdata;
            nt = 1;
          end else begin
            m_cnt++;
            if (m_cnt == TO) ne = 1;
            else nw = 1;
          end
        end
        if (m_xfer) begin
          m_ir = m_mdr;
          nh = 1;
        end
        if (start) nl = 1;
      end
      m_load = nl; m_wait = nw; m_xfer = nt; m_hold = nh; m_err = ne;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gate_pc_en", 32'(gate_pc_en), 32'(m_load));
      chk("ld_pc",      32'(ld_pc),      32'(m_load));
      chk("pc_sel",     32'(pc_sel),     32'h0);
      chk("mem_en",     32'(mem_en),     32'(m_wait));
      chk("mem_addr",   32'(mem_addr),   32'(m_mar));
      chk("ir",         32'(ir),         32'(m_ir));
      chk("ir_valid",   32'(ir_valid),   32'(m_hold));
      chk("busy",       32'(busy),       32'(m_load | m_wait | m_xfer | m_hold));
      chk("fetch_err",  32'(fetch_err),  32'(m_err));
    end
  end

  task automatic step(input bit fr, input bit fl, input bit mr, input bit ack);
    fetch_req = fr; flush = fl; mem_r = mr; ir_ack = ack;
    @(posedge clk); #1;
    pc_ld_req = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_ld_req = 1'b1;
    pc_ld_val = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and idle state
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // 1: zero-wait fetch from 3000
    set_pc(16'h3000);
    step(1, 0, 1, 0);
    chk("t1_ld_pc_c1", 32'(ld_pc), 32'h1);
    chk("t1_gate_c1", 32'(gate_pc_en), 32'h1);
    step(0, 0, 1, 0);
    chk("t1_addr_c2", 32'(mem_addr), 32'h3000);
    chk("t1_mem_en_c2", 32'(mem_en), 32'h1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t1_ir_c4", 32'(ir), 32'h1261);
    chk("t1_valid_c4", 32'(ir_valid), 32'h1);
    chk("t1_pc", 32'(pc_stub), 32'h3001);
    step(0, 0, 0, 1);
    chk("t1_ack_valid", 32'(ir_valid), 32'h0);

    // 2: three wait states, ready on the last permitted cycle
    set_pc(16'h3010);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t2_mem_en_c5", 32'(mem_en), 32'h1);
    chk("t2_addr_c5", 32'(mem_addr), 32'h3010);
    step(0, 0, 1, 0);
    chk("t2_no_err", 32'(fetch_err), 32'h0);
    step(0, 0, 0, 0);
    chk("t2_valid_c7", 32'(ir_valid), 32'h1);
    chk("t2_ir_c7", 32'(ir), 32'h95B5);
    step(0, 0, 0, 1);

    // 3: memory never ready -> timeout
    set_pc(16'h3020);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_still_wait", 32'(mem_en), 32'h1);
    step(0, 0, 0, 0);
    chk("t3_err", 32'(fetch_err), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_valid", 32'(ir_valid), 32'h0);
    chk("t3_pc", 32'(pc_stub), 32'h3021);
    step(0, 0, 1, 0);
    chk("t3_err_pulse", 32'(fetch_err), 32'h0);
    chk("t3_ir_kept", 32'(ir), 32'h95B5);
    step(0, 0, 0, 0);
    chk("t3_late_mem_r", 32'(busy), 32'h0);

    // 4: back-to-back fetches
    set_pc(16'h3000);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("t4_ir_a", 32'(ir), 32'h1261);
    step(1, 0, 1, 1);
    chk("t4_refetch", 32'(ld_pc), 32'h1);
    step(0, 0, 1, 0);
    chk("t4_addr_b", 32'(mem_addr), 32'h3001);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t4_ir_b", 32'(ir), 32'h0FFE);
    step(0, 0, 0, 1);

    // 5: flush in FETCH2, then late ready
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t5_flush_busy", 32'(busy), 32'h0);
    step(0, 0, 1, 0);
    chk("t5_ir_kept", 32'(ir), 32'h0FFE);
    chk("t5_valid", 32'(ir_valid), 32'h0);
    chk("t5_mar", 32'(mem_addr), 32'h3002);
    chk("t5_pc", 32'(pc_stub), 32'h3003);
    // flush together with ir_ack in VALID
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("t5_ir_c", 32'(ir), 32'h95A6);
    step(1, 1, 0, 1);
    chk("t5_no_fetch1", 32'(ld_pc), 32'h0);
    chk("t5_idle", 32'(busy), 32'h0);
    chk("t5_ir_c_kept", 32'(ir), 32'h95A6);
    // flush in FETCH1: PC still advances, MAR untouched
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("t5_f1_pc", 32'(pc_stub), 32'h3005);
    chk("t5_f1_mar", 32'(mem_addr), 32'h3003);

    // 6: reset in FETCH2 and in VALID
    set_pc(16'h3000);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk("t6_f2_mem_en", 32'(mem_en), 32'h0);
    chk("t6_f2_mar", 32'(mem_addr), 32'h0);
    chk("t6_f2_ir", 32'(ir), 32'h0);
    set_pc(16'h3000);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t6_ir_a", 32'(ir), 32'h1261);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk("t6_v_valid", 32'(ir_valid), 32'h0);
    chk("t6_v_ir", 32'(ir), 32'h0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t6_ir_b", 32'(ir), 32'h0FFE);
    chk("t6_valid_b", 32'(ir_valid), 32'h1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
